// File: rtl/instr_encoder.sv
// Instruction encoder and instruction-memory loader: packs decoded fields into
// RV32I I/S/B/R words and streams them to memory through a ready handshake.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  fmt_e              fmt;
  logic [ADDR_W:0]   wrPtr;
  logic [31:0]       encWord;
  logic              immLegal;
  logic              accept;

  assign fmt = fmt_e'(ImmSrc);

  // wrPtr saturates at exactly 2^ADDR_W, so its top bit alone marks full.
  assign full     = wrPtr[ADDR_W];
  assign in_ready = !full && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;

  // Field packing and immediate range check for the selected format.
  always_comb begin
    encWord  = 32'd0;
    immLegal = 1'b1;
    unique case (fmt)
      FMT_I: begin
        encWord  = {imm[11:0], rs1, funct3, rd, opcode};
        immLegal = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      FMT_S: begin
        encWord  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        immLegal = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      FMT_B: begin
        encWord  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        immLegal = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      end
      FMT_R: begin
        encWord  = {funct7, rs2, rs1, funct3, rd, opcode};
        immLegal = 1'b1;
      end
      default: begin
        encWord  = 32'd0;
        immLegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
      wrPtr     <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else if (clear) begin
      mem_we   <= 1'b0;
      wrPtr    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      // A legal accept reloads the output register even while the previous
      // word is completing, giving back-to-back writes.
      if (accept && immLegal) begin
        mem_we    <= 1'b1;
        mem_wdata <= encWord;
        mem_waddr <= wrPtr[ADDR_W-1:0];
        wrPtr     <= wrPtr + (ADDR_W+1)'(1);
      end else if (mem_we && mem_ready) begin
        mem_we <= 1'b0;
      end
      if (accept && !immLegal && !err) begin
        err      <= 1'b1;
        err_addr <= wrPtr[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_instr_encoder;

  localparam int ADDR_W = 3;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_ready, mem_we, mem_ready, full, err;
  logic [1:0]        ImmSrc;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [31:0]       imm, mem_wdata, heldWdata;
  logic [ADDR_W-1:0] mem_waddr, err_addr, heldWaddr;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state: pointer as a plain integer, pending word as values.
  logic        mWe;
  logic [31:0] mWdata, mImm;
  logic [1:0]  mFmt;
  int          mWaddr, mPtr, mErrAddr;
  logic        mErr;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .full(full), .err(err),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic bit legalImm(logic [1:0] f, logic [31:0] v);
    int s;
    s = $signed(v);
    case (f)
      2'b00, 2'b01: return (s >= -2048) && (s <= 2047);
      2'b10:        return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      default:      return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] encode(logic [1:0] f, logic [6:0] op, logic [4:0] d,
                                         logic [4:0] s1, logic [4:0] s2, logic [2:0] f3,
                                         logic [6:0] f7, logic [31:0] v);
    logic [31:0] w;
    w = 32'd0;
    w[6:0]   = op;
    w[14:12] = f3;
    w[19:15] = s1;
    case (f)
      2'b00: begin w[11:7] = d; w[31:20] = v[11:0]; end
      2'b01: begin w[11:7] = v[4:0]; w[24:20] = s2; w[31:25] = v[11:5]; end
      2'b10: begin
        w[7] = v[11]; w[11:8] = v[4:1]; w[24:20] = s2; w[30:25] = v[10:5]; w[31] = v[12];
      end
      default: begin w[11:7] = d; w[24:20] = s2; w[31:25] = f7; end
    endcase
    return w;
  endfunction

  // Sign-extender view of a word: what the core would recover as the immediate.
  function automatic logic [31:0] decodeImm(logic [1:0] f, logic [31:0] w);
    case (f)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      default: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the handshake rules, applied on each active edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mWe <= 1'b0; mWdata <= 32'd0; mWaddr <= 0; mPtr <= 0; mErr <= 1'b0; mErrAddr <= 0;
      mImm <= 32'd0; mFmt <= 2'b11;
    end else if (clear) begin
      mWe <= 1'b0; mPtr <= 0; mErr <= 1'b0; mErrAddr <= 0;
    end else begin
      if (in_valid && mPtr < CAP && (!mWe || mem_ready)) begin
        if (legalImm(ImmSrc, imm)) begin
          mWe    <= 1'b1;
          mWdata <= encode(ImmSrc, opcode, rd, rs1, rs2, funct3, funct7, imm);
          mWaddr <= mPtr;
          mPtr   <= mPtr + 1;
          mImm   <= imm;
          mFmt   <= ImmSrc;
        end else begin
          if (mWe && mem_ready) mWe <= 1'b0;
          if (!mErr) begin
            mErr     <= 1'b1;
            mErrAddr <= mPtr % CAP;
          end
        end
      end else if (mWe && mem_ready) begin
        mWe <= 1'b0;
      end
    end
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("mem_we", 32'(mem_we), 32'(mWe));
      checkOutput("in_ready", 32'(in_ready), 32'((mPtr < CAP) && (!mWe || mem_ready)));
      checkOutput("full", 32'(full), 32'(mPtr == CAP));
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("err_addr", 32'(err_addr), 32'(mErrAddr));
      if (mWe) begin
        checkOutput("mem_waddr", 32'(mem_waddr), 32'(mWaddr));
        checkOutput("mem_wdata", mem_wdata, mWdata);
        if (mFmt != 2'b11) checkOutput("roundtrip_imm", decodeImm(mFmt, mem_wdata), mImm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [6:0] op,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v32);
    in_valid = v; ImmSrc = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = v32;
  endtask

  task automatic addi(input logic [4:0] d, input logic [31:0] v32);
    applyStimulus(1'b1, 2'b00, 7'b0010011, d, 5'd0, 5'd0, 3'd0, 7'd0, v32);
  endtask

  task automatic doClear();
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [31:0] pickImm();
    int bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 4096, -1};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       return 32'(bnd[$urandom_range(0, 9)]);
      2:       return $urandom();
      default: return 32'($urandom_range(0, 8190)) - 32'd4096;
    endcase
  endfunction

  initial begin
    reset = 1'b1; clear = 1'b0; mem_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'({err, err_addr}), 32'd0);
    reset = 1'b0;
    tick();

    // addi x1,x0,5
    mem_ready = 1'b1;
    addi(5'd1, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("addi_we", 32'(mem_we), 32'd1);
    checkOutput("addi_addr", 32'(mem_waddr), 32'd0);
    checkOutput("addi_word", mem_wdata, 32'h00500093);
    tick();

    // sw x5,-4(x2) then beq x1,x2,-8 back-to-back
    doClear();
    applyStimulus(1'b1, 2'b01, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFFFFFC);
    tick();
    applyStimulus(1'b1, 2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFF8);
    checkOutput("sw_word", mem_wdata, 32'hFE512E23);
    checkOutput("sw_addr", 32'(mem_waddr), 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("beq_word", mem_wdata, 32'hFE208CE3);
    checkOutput("beq_addr", 32'(mem_waddr), 32'd1);
    checkOutput("beq_we", 32'(mem_we), 32'd1);
    tick();

    // Range errors, then a legal word still lands at address 0
    doClear();
    addi(5'd1, 32'd2048);
    tick();
    checkOutput("rng_err", 32'(err), 32'd1);
    checkOutput("rng_err_addr", 32'(err_addr), 32'd0);
    checkOutput("rng_no_we", 32'(mem_we), 32'd0);
    applyStimulus(1'b1, 2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    tick();
    checkOutput("rng_b_no_we", 32'(mem_we), 32'd0);
    checkOutput("rng_err_addr_kept", 32'(err_addr), 32'd0);
    addi(5'd1, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("rng_legal_addr", 32'(mem_waddr), 32'd0);
    checkOutput("rng_legal_we", 32'(mem_we), 32'd1);
    tick();

    // Backpressure
    doClear();
    mem_ready = 1'b0;
    addi(5'd1, 32'd5);
    tick();
    addi(5'd2, 32'd7);
    heldWdata = mem_wdata;
    heldWaddr = mem_waddr;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_wdata_held", mem_wdata, heldWdata);
      checkOutput("bp_waddr_held", 32'(mem_waddr), 32'(heldWaddr));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_next_addr", 32'(mem_waddr), 32'd1);
    checkOutput("bp_next_word", mem_wdata, 32'h00700113);
    tick();

    // Fill to capacity, then clear
    doClear();
    addi(5'd1, 32'd5);
    repeat (CAP) tick();
    checkOutput("full_set", 32'(full), 32'd1);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_last_addr", 32'(mem_waddr), 32'(CAP - 1));
    tick();
    checkOutput("full_drained", 32'(mem_we), 32'd0);
    doClear();
    checkOutput("full_cleared", 32'(full), 32'd0);
    addi(5'd1, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("full_restart_addr", 32'(mem_waddr), 32'd0);
    tick();

    // Asynchronous reset while a word is pending
    mem_ready = 1'b0;
    addi(5'd3, 32'd9);
    tick();
    in_valid = 1'b0;
    checkOutput("arst_pending", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("arst_we", 32'(mem_we), 32'd0);
    checkOutput("arst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("arst_wdata", mem_wdata, 32'd0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    addi(5'd1, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("arst_first_addr", 32'(mem_waddr), 32'd0);
    tick();

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 7'($urandom()),
                    5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
                    7'($urandom()), pickImm());
      mem_ready = $urandom_range(0, 9) < 7;
      clear     = $urandom_range(0, 47) == 0;
      tick();
    end
    clear = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
